// File: rtl/pipe_ctrl.sv
// Hazard and flush sequencer for the 5-stage core.
// Drives enable/clear of the pipe registers and keeps stall/flush counters.
module pipe_ctrl #(
    parameter int unsigned MDU_LAT = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rd_e,
    input  logic             memread_e,
    input  logic             redirect_e,
    input  logic             mdu_start_e,
    input  logic             halt,
    output logic             en_pc,
    output logic             en_fd,
    output logic             clr_fd,
    output logic             en_de,
    output logic             clr_de,
    output logic             en_em,
    output logic             clr_em,
    output logic             en_mw,
    output logic             clr_mw,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam bit MDU_EN = (MDU_LAT >= 2);
    localparam logic [7:0] MDU_LOAD = MDU_EN ? 8'(MDU_LAT - 1) : 8'd0;

    typedef enum logic {
        RUN,
        MDU_WAIT
    } state_t;

    typedef enum logic [2:0] {
        ACT_ADV,
        ACT_FLUSH,
        ACT_LU,
        ACT_MS,
        ACT_HALT
    } act_t;

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    act_t             act;
    logic             stall_inc;
    logic             flush_inc;
    logic             load_use;

    assign load_use = memread_e && (rd_e != 5'd0) &&
                      ((rd_e == rs1_d) || (rd_e == rs2_d));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        act       = ACT_ADV;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        unique case (state_q)
            RUN: begin
                if (halt) begin
                    act = ACT_HALT;
                end else if (redirect_e) begin
                    act       = ACT_FLUSH;
                    flush_inc = 1'b1;
                end else if (mdu_start_e && MDU_EN) begin
                    act       = ACT_MS;
                    cnt_d     = MDU_LOAD;
                    state_d   = MDU_WAIT;
                    stall_inc = 1'b1;
                end else if (load_use) begin
                    act       = ACT_LU;
                    stall_inc = 1'b1;
                end
            end
            MDU_WAIT: begin
                if (halt) begin
                    act = ACT_HALT;
                end else if (cnt_q > 8'd1) begin
                    act       = ACT_MS;
                    cnt_d     = cnt_q - 8'd1;
                    stall_inc = 1'b1;
                end else begin
                    // Last EX cycle of the MDU op; treat cnt==0 the same way
                    state_d = RUN;
                    cnt_d   = 8'd0;
                    if (load_use) begin
                        act       = ACT_LU;
                        stall_inc = 1'b1;
                    end
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (stall_inc && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
        if (flush_inc && (flush_q != {CNT_W{1'b1}})) begin
            flush_d = flush_q + 1'b1;
        end
    end

    always_comb begin
        en_pc  = 1'b1;
        en_fd  = 1'b1;
        en_de  = 1'b1;
        en_em  = 1'b1;
        en_mw  = 1'b1;
        clr_fd = 1'b0;
        clr_de = 1'b0;
        clr_em = 1'b0;
        clr_mw = 1'b0;
        unique case (act)
            ACT_ADV: begin
            end
            ACT_FLUSH: begin
                clr_fd = 1'b1;
                clr_de = 1'b1;
            end
            ACT_LU: begin
                en_pc  = 1'b0;
                en_fd  = 1'b0;
                clr_de = 1'b1;
            end
            ACT_MS: begin
                en_pc  = 1'b0;
                en_fd  = 1'b0;
                en_de  = 1'b0;
                clr_em = 1'b1;
            end
            ACT_HALT: begin
                en_pc = 1'b0;
                en_fd = 1'b0;
                en_de = 1'b0;
                en_em = 1'b0;
                en_mw = 1'b0;
            end
            default: begin
            end
        endcase
        // Hold the whole pipe cleared while reset is asserted
        if (!rst_n) begin
            en_pc  = 1'b0;
            en_fd  = 1'b0;
            en_de  = 1'b0;
            en_em  = 1'b0;
            en_mw  = 1'b0;
            clr_fd = 1'b1;
            clr_de = 1'b1;
            clr_em = 1'b1;
            clr_mw = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= 8'd0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_cnt    = flush_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: default, narrow-counter and MDU-disabled
// instances share one input stream.
module tb_pipe_ctrl;

    localparam logic [8:0] C_ADV = 9'b11111_0000;
    localparam logic [8:0] C_RST = 9'b00000_1111;
    localparam logic [8:0] C_HLT = 9'b00000_0000;
    localparam logic [8:0] C_FLS = 9'b11111_1100;
    localparam logic [8:0] C_LU  = 9'b00111_0100;
    localparam logic [8:0] C_MS  = 9'b00011_0010;

    logic       clk;
    logic       rst_n;
    logic [4:0] rs1_d, rs2_d, rd_e;
    logic       memread_e, redirect_e, mdu_start_e, halt;

    logic        a_pc, a_fd, a_cfd, a_de, a_cde, a_em, a_cem, a_mw, a_cmw;
    logic        b_pc, b_fd, b_cfd, b_de, b_cde, b_em, b_cem, b_mw, b_cmw;
    logic        c_pc, c_fd, c_cfd, c_de, c_cde, c_em, c_cem, c_mw, c_cmw;
    logic [15:0] a_stall, a_flush, c_stall, c_flush;
    logic [3:0]  b_stall, b_flush;
    logic [8:0]  ctl_a, ctl_c;

    int n_chk  = 0;
    int n_pass = 0;

    assign ctl_a = {a_pc, a_fd, a_de, a_em, a_mw, a_cfd, a_cde, a_cem, a_cmw};
    assign ctl_c = {c_pc, c_fd, c_de, c_em, c_mw, c_cfd, c_cde, c_cem, c_cmw};

    pipe_ctrl #(.MDU_LAT(4), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .rs1_d(rs1_d), .rs2_d(rs2_d),
        .rd_e(rd_e), .memread_e(memread_e), .redirect_e(redirect_e),
        .mdu_start_e(mdu_start_e), .halt(halt),
        .en_pc(a_pc), .en_fd(a_fd), .clr_fd(a_cfd), .en_de(a_de),
        .clr_de(a_cde), .en_em(a_em), .clr_em(a_cem), .en_mw(a_mw),
        .clr_mw(a_cmw), .stall_cycles(a_stall), .flush_cnt(a_flush)
    );

    pipe_ctrl #(.MDU_LAT(4), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .rs1_d(rs1_d), .rs2_d(rs2_d),
        .rd_e(rd_e), .memread_e(memread_e), .redirect_e(redirect_e),
        .mdu_start_e(mdu_start_e), .halt(halt),
        .en_pc(b_pc), .en_fd(b_fd), .clr_fd(b_cfd), .en_de(b_de),
        .clr_de(b_cde), .en_em(b_em), .clr_em(b_cem), .en_mw(b_mw),
        .clr_mw(b_cmw), .stall_cycles(b_stall), .flush_cnt(b_flush)
    );

    pipe_ctrl #(.MDU_LAT(1), .CNT_W(16)) u_nomdu (
        .clk(clk), .rst_n(rst_n), .rs1_d(rs1_d), .rs2_d(rs2_d),
        .rd_e(rd_e), .memread_e(memread_e), .redirect_e(redirect_e),
        .mdu_start_e(mdu_start_e), .halt(halt),
        .en_pc(c_pc), .en_fd(c_fd), .clr_fd(c_cfd), .en_de(c_de),
        .clr_de(c_cde), .en_em(c_em), .clr_em(c_cem), .en_mw(c_mw),
        .clr_mw(c_cmw), .stall_cycles(c_stall), .flush_cnt(c_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drv(input logic mr, input logic [4:0] rd,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic rdr, input logic mdu, input logic h);
        memread_e   = mr;
        rd_e        = rd;
        rs1_d       = r1;
        rs2_d       = r2;
        redirect_e  = rdr;
        mdu_start_e = mdu;
        halt        = h;
    endtask

    task automatic idle();
        drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst_ctl%0d", i), 32'(ctl_a), 32'(C_RST));
        end
        chk("rst_stall", 32'(a_stall), 32'd0);
        chk("rst_flush", 32'(a_flush), 32'd0);
        nxt();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ctl", 32'(ctl_a), 32'(C_ADV));
        nxt();
        chk("rel_stall", 32'(a_stall), 32'd0);
        chk("rel_flush", 32'(a_flush), 32'd0);

        // load-use on rs2
        drv(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("lu_ctl", 32'(ctl_a), 32'(C_LU));
        nxt();
        chk("lu_stall", 32'(a_stall), 32'd1);
        idle();
        @(negedge clk);
        chk("lu_after", 32'(ctl_a), 32'(C_ADV));
        nxt();
        // rd_e=0 never stalls
        drv(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("x0_ctl", 32'(ctl_a), 32'(C_ADV));
        nxt();
        chk("x0_stall", 32'(a_stall), 32'd1);

        // redirect beats load-use
        drv(1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("rdr_ctl", 32'(ctl_a), 32'(C_FLS));
        nxt();
        chk("rdr_flush", 32'(a_flush), 32'd1);
        chk("rdr_stall", 32'(a_stall), 32'd1);
        idle();
        nxt();

        // MDU op, redirect at t+1 ignored, load-use on the last EX cycle
        drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("mdu_t0", 32'(ctl_a), 32'(C_MS));
        chk("nomdu_t0", 32'(ctl_c), 32'(C_ADV));
        nxt();
        redirect_e = 1'b1;
        @(negedge clk);
        chk("mdu_t1", 32'(ctl_a), 32'(C_MS));
        nxt();
        redirect_e = 1'b0;
        @(negedge clk);
        chk("mdu_t2", 32'(ctl_a), 32'(C_MS));
        nxt();
        drv(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("mdu_t3_lu", 32'(ctl_a), 32'(C_LU));
        nxt();
        idle();
        @(negedge clk);
        chk("mdu_t4", 32'(ctl_a), 32'(C_ADV));
        nxt();
        chk("mdu_stall", 32'(a_stall), 32'd5);
        chk("mdu_flush", 32'(a_flush), 32'd1);
        chk("nomdu_stall", 32'(c_stall), 32'd2);
        chk("nomdu_flush", 32'(c_flush), 32'd2);

        // halt inside MDU_WAIT
        drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("hm_t0", 32'(ctl_a), 32'(C_MS));
        nxt();
        halt = 1'b1;
        @(negedge clk);
        chk("hm_t1", 32'(ctl_a), 32'(C_HLT));
        chk("hm_nomdu", 32'(ctl_c), 32'(C_HLT));
        nxt();
        @(negedge clk);
        chk("hm_t2", 32'(ctl_a), 32'(C_HLT));
        nxt();
        halt = 1'b0;
        @(negedge clk);
        chk("hm_t3", 32'(ctl_a), 32'(C_MS));
        nxt();
        @(negedge clk);
        chk("hm_t4", 32'(ctl_a), 32'(C_MS));
        nxt();
        @(negedge clk);
        chk("hm_t5", 32'(ctl_a), 32'(C_ADV));
        nxt();
        idle();
        nxt();
        chk("hm_stall", 32'(a_stall), 32'd8);
        chk("hm_sat", 32'(b_stall), 32'd8);
        chk("hm_nomdu_st", 32'(c_stall), 32'd2);

        // 20 load-use cycles saturate the 4-bit counter
        drv(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) nxt();
        @(negedge clk);
        chk("sat_ctl", 32'(ctl_a), 32'(C_LU));
        chk("sat_b", 32'(b_stall), 32'hf);
        chk("sat_a", 32'(a_stall), 32'd28);
        chk("sat_c", 32'(c_stall), 32'd22);
        nxt();
        idle();
        nxt();
        chk("sat_hold", 32'(b_stall), 32'hf);

        // async reset in the middle of MDU_WAIT
        mdu_start_e = 1'b1;
        nxt();
        @(negedge clk);
        chk("ar_wait", 32'(ctl_a), 32'(C_MS));
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_ctl", 32'(ctl_a), 32'(C_RST));
        chk("ar_stall", 32'(a_stall), 32'd0);
        chk("ar_sat", 32'(b_stall), 32'd0);
        idle();
        nxt();
        nxt();
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_run", 32'(ctl_a), 32'(C_ADV));
        nxt();
        chk("ar_stall2", 32'(a_stall), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
